// File: rtl/sram_1rw_byte_mask_arbiter.sv
// ---------------------------------------------------------------------------
// sram_1rw_byte_mask_arbiter
//
// Shares one single-port (1RW) synchronous SRAM with a byte write mask
// between two requesters. After reset the whole array is written with zeros.
// The two ports are then arbitrated round-robin. Each port has a one-entry
// read response slot, so a requester can stall on its read data without
// blocking the other port.
//
// Ports:
//   clk_i             clock; all state changes on the rising edge
//   reset_n_i         asynchronous active-low reset
//   v_i[1:0]          per-port request valid
//   w_i[1:0]          per-port write (1) / read (0)
//   addr_i            per-port address, port i at [i*addr_width_p +: addr_width_p]
//   data_i            per-port write data
//   write_mask_i      per-port byte write mask
//   ready_o[1:0]      request accepted this cycle (a transfer is v_i & ready_o)
//   data_v_o[1:0]     per-port read response valid
//   data_o            per-port read response data
//   yumi_i[1:0]       per-port response consumed (only while data_v_o is set)
//   mem_*_o           SRAM macro request: enable, write, address, data, mask
//   mem_data_i        SRAM read data, valid the cycle after a read
//   init_done_o       array clear finished; requests may be granted
// ---------------------------------------------------------------------------
module sram_1rw_byte_mask_arbiter #(
    parameter int els_p            = 512,
    parameter int data_width_p     = 64,
    parameter int addr_width_p     = $clog2(els_p),
    parameter int mask_width_p     = data_width_p / 8,
    parameter bit clear_on_reset_p = 1'b1
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,

    input  logic [1:0]                v_i,
    input  logic [1:0]                w_i,
    input  logic [2*addr_width_p-1:0] addr_i,
    input  logic [2*data_width_p-1:0] data_i,
    input  logic [2*mask_width_p-1:0] write_mask_i,
    output logic [1:0]                ready_o,

    output logic [1:0]                data_v_o,
    output logic [2*data_width_p-1:0] data_o,
    input  logic [1:0]                yumi_i,

    output logic                      mem_v_o,
    output logic                      mem_w_o,
    output logic [addr_width_p-1:0]   mem_addr_o,
    output logic [data_width_p-1:0]   mem_data_o,
    output logic [mask_width_p-1:0]   mem_write_mask_o,
    input  logic [data_width_p-1:0]   mem_data_i,

    output logic                      init_done_o
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic [addr_width_p-1:0] last_addr_lp = addr_width_p'(els_p - 1);

    state_e                    state_r, state_n;
    logic [addr_width_p-1:0]   cnt_r, cnt_n;
    logic                      last_grant_r;  // port granted most recently
    logic [1:0]                inflight_r;    // read issued last cycle, data on mem_data_i now
    logic [1:0]                full_r;        // response parked in rsp_buf_r
    logic [data_width_p-1:0]   rsp_buf_r [2];

    logic [1:0]                occ;
    logic [1:0]                elig;
    logic [1:0]                grant;
    logic                      sel;

    // -----------------------------------------------------------------------
    // Clear sequencer: walks the counter across the array once, then RUN.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinationally assigned signal gets a default first so
        // no path through the block leaves it unassigned (which would infer a latch).
        state_n = state_r;
        cnt_n   = cnt_r;
        if (state_r == ST_INIT) begin
            cnt_n = cnt_r + 1'b1;
            if (cnt_r == last_addr_lp) begin
                state_n = ST_RUN;
                cnt_n   = '0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Eligibility and round-robin arbitration.
    // A read is only eligible if its response slot is free now or is being
    // freed by yumi_i this cycle; writes produce no response and always go.
    // -----------------------------------------------------------------------
    always_comb begin
        occ   = full_r | inflight_r;
        elig  = v_i & (w_i | ~occ | yumi_i);
        grant = 2'b00;
        if (state_r == ST_RUN) begin
            unique case (elig)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_grant_r ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    assign sel = grant[1];

    // Outputs are forced idle while reset is held, independent of state.
    assign ready_o     = grant & {2{reset_n_i}};
    assign init_done_o = (state_r == ST_RUN);

    // -----------------------------------------------------------------------
    // SRAM drive: clear writes during INIT, granted port's request in RUN.
    // -----------------------------------------------------------------------
    always_comb begin
        mem_v_o          = 1'b0;
        mem_w_o          = 1'b0;
        mem_addr_o       = '0;
        mem_data_o       = '0;
        mem_write_mask_o = '0;
        if (state_r == ST_INIT) begin
            mem_v_o          = reset_n_i;
            mem_w_o          = 1'b1;
            mem_addr_o       = cnt_r;
            mem_write_mask_o = '1;
        end else if (|grant) begin
            mem_v_o          = reset_n_i;
            mem_w_o          = w_i[sel];
            mem_addr_o       = sel ? addr_i[2*addr_width_p-1:addr_width_p]
                                   : addr_i[addr_width_p-1:0];
            mem_data_o       = sel ? data_i[2*data_width_p-1:data_width_p]
                                   : data_i[data_width_p-1:0];
            mem_write_mask_o = sel ? write_mask_i[2*mask_width_p-1:mask_width_p]
                                   : write_mask_i[mask_width_p-1:0];
        end
    end

    // -----------------------------------------------------------------------
    // Control state.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!reset_n_i) begin
            if (clear_on_reset_p) state_r <= ST_INIT;
            else                  state_r <= ST_RUN;
            cnt_r        <= '0;
            last_grant_r <= 1'b1;
            inflight_r   <= 2'b00;
            full_r       <= 2'b00;
        end else begin
            state_r    <= state_n;
            cnt_r      <= cnt_n;
            inflight_r <= grant & ~w_i;
            if (|grant) last_grant_r <= sel;
            for (int i = 0; i < 2; i++) begin
                if (inflight_r[i] && !yumi_i[i]) full_r[i] <= 1'b1;
                else if (full_r[i] && yumi_i[i]) full_r[i] <= 1'b0;
            end
        end
    end

    // NOTE: the response buffers carry no reset; their contents are only
    // observed while full_r is set, and full_r itself is reset.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < 2; i++) begin
            if (inflight_r[i] && !yumi_i[i]) rsp_buf_r[i] <= mem_data_i;
        end
    end

    // -----------------------------------------------------------------------
    // Read return: SRAM data bypasses straight out on the first cycle and is
    // served from the buffer afterwards until consumed.
    // -----------------------------------------------------------------------
    assign data_v_o = full_r | inflight_r;
    assign data_o   = {full_r[1] ? rsp_buf_r[1] : mem_data_i,
                       full_r[0] ? rsp_buf_r[0] : mem_data_i};

endmodule

// File: tb/tb_sram_1rw_byte_mask_arbiter.sv
// ---------------------------------------------------------------------------
// Directed self-checking bench for sram_1rw_byte_mask_arbiter.
// A small behavioural byte-masked SRAM (1-cycle read latency) is attached to
// the mem_* interface; its initial contents are non-zero garbage so the
// post-reset clear is observable through later reads.
// ---------------------------------------------------------------------------
module tb_sram_1rw_byte_mask_arbiter;

    logic          clk;
    logic          reset_n;
    logic [1:0]    v, w, yumi;
    logic [8:0]    a0, a1;
    logic [63:0]   d0, d1;
    logic [7:0]    m0, m1;
    logic [1:0]    ready;
    logic [1:0]    data_v;
    logic [127:0]  data;
    logic          mem_v, mem_w;
    logic [8:0]    mem_addr;
    logic [63:0]   mem_wdata;
    logic [7:0]    mem_mask;
    logic [63:0]   mem_rdata;
    logic          init_done;

    int checks = 0;
    int errors = 0;

    sram_1rw_byte_mask_arbiter dut (
        .clk_i            (clk),
        .reset_n_i        (reset_n),
        .v_i              (v),
        .w_i              (w),
        .addr_i           ({a1, a0}),
        .data_i           ({d1, d0}),
        .write_mask_i     ({m1, m0}),
        .ready_o          (ready),
        .data_v_o         (data_v),
        .data_o           (data),
        .yumi_i           (yumi),
        .mem_v_o          (mem_v),
        .mem_w_o          (mem_w),
        .mem_addr_o       (mem_addr),
        .mem_data_o       (mem_wdata),
        .mem_write_mask_o (mem_mask),
        .mem_data_i       (mem_rdata),
        .init_done_o      (init_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural SRAM macro.
    logic [63:0] mem [512];
    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 64'hDEAD_BEEF_DEAD_BEEF;
    end
    always @(posedge clk) begin
        if (mem_v) begin
            if (mem_w) begin
                for (int b = 0; b < 8; b++)
                    if (mem_mask[b]) mem[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            end else begin
                mem_rdata <= mem[mem_addr];
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive request inputs, then let combinational outputs settle.
    task automatic req(input logic [1:0] vv, input logic [1:0] ww,
                       input logic [8:0] aa0, input logic [8:0] aa1,
                       input logic [1:0] yy);
        v = vv; w = ww; a0 = aa0; a1 = aa1; yumi = yy;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Walk the clear sequence: 512 masked zero-writes at addresses 0..511.
    task automatic init_check();
        for (int i = 0; i < 512; i++) begin
            check("init_mem_v",     64'(mem_v),     64'd1);
            check("init_mem_w",     64'(mem_w),     64'd1);
            check("init_addr",      64'(mem_addr),  64'(i));
            check("init_data",      mem_wdata,      64'd0);
            check("init_mask",      64'(mem_mask),  64'hFF);
            check("init_ready",     64'(ready),     64'd0);
            check("init_done_low",  64'(init_done), 64'd0);
            tick();
        end
        req(2'b00, 2'b00, 9'd0, 9'd0, 2'b00);
        check("init_done_high", 64'(init_done), 64'd1);
        check("run_idle_mem_v", 64'(mem_v),     64'd0);
    endtask

    logic [63:0] exp_rd [8];

    initial begin
        reset_n = 1'b0;
        v = '0; w = '0; yumi = '0; a0 = '0; a1 = '0;
        d0 = '0; d1 = '0; m0 = '0; m1 = '0;
        #2;
        check("rst_ready",     64'(ready),     64'd0);
        check("rst_data_v",    64'(data_v),    64'd0);
        check("rst_init_done", 64'(init_done), 64'd0);
        check("rst_mem_v",     64'(mem_v),     64'd0);
        tick();
        tick();
        reset_n = 1'b1;
        req(2'b11, 2'b00, 9'd3, 9'd4, 2'b00);
        init_check();

        // Masked write then read-back on port 0.
        d0 = 64'h1122_3344_5566_7788; m0 = 8'h0F;
        req(2'b01, 2'b01, 9'd5, 9'd0, 2'b00);
        check("wr0_ready",    64'(ready),    64'b01);
        check("wr0_mem_v",    64'(mem_v),    64'd1);
        check("wr0_mem_w",    64'(mem_w),    64'd1);
        check("wr0_mem_addr", 64'(mem_addr), 64'd5);
        check("wr0_mem_mask", 64'(mem_mask), 64'h0F);
        check("wr0_mem_data", mem_wdata,     64'h1122_3344_5566_7788);
        tick();
        req(2'b01, 2'b00, 9'd5, 9'd0, 2'b00);
        check("rd0_ready", 64'(ready), 64'b01);
        check("rd0_mem_w", 64'(mem_w), 64'd0);
        tick();
        req(2'b00, 2'b00, 9'd0, 9'd0, 2'b01);
        check("rd0_data_v", 64'(data_v),   64'b01);
        check("rd0_data",   data[63:0],    64'h0000_0000_5566_7788);
        tick();
        req(2'b00, 2'b00, 9'd0, 9'd0, 2'b00);
        check("rd0_done", 64'(data_v), 64'b00);

        // Port 1 full-mask write to addr 6.
        d1 = 64'hCAFE_F00D_1234_5678; m1 = 8'hFF;
        req(2'b10, 2'b10, 9'd0, 9'd6, 2'b00);
        check("wr1_ready",    64'(ready),    64'b10);
        check("wr1_mem_addr", 64'(mem_addr), 64'd6);
        tick();

        // Both ports read continuously, yumi high: grants alternate from port 0.
        req(2'b11, 2'b00, 9'd5, 9'd6, 2'b11);
        check("rr_c0_ready",  64'(ready),  64'b01);
        check("rr_c0_data_v", 64'(data_v), 64'b00);
        tick();
        check("rr_c1_ready",  64'(ready),   64'b10);
        check("rr_c1_data_v", 64'(data_v),  64'b01);
        check("rr_c1_data0",  data[63:0],   64'h0000_0000_5566_7788);
        tick();
        check("rr_c2_ready",  64'(ready),   64'b01);
        check("rr_c2_data_v", 64'(data_v),  64'b10);
        check("rr_c2_data1",  data[127:64], 64'hCAFE_F00D_1234_5678);
        tick();
        check("rr_c3_ready",  64'(ready),   64'b10);
        check("rr_c3_data_v", 64'(data_v),  64'b01);
        check("rr_c3_data0",  data[63:0],   64'h0000_0000_5566_7788);
        tick();
        req(2'b00, 2'b00, 9'd5, 9'd6, 2'b11);
        check("rr_c4_data_v", 64'(data_v),  64'b10);
        check("rr_c4_data1",  data[127:64], 64'hCAFE_F00D_1234_5678);
        tick();
        check("rr_c5_data_v", 64'(data_v),  64'b00);

        // Port 1 backpressure: response held in buffer, reads blocked, writes pass.
        req(2'b10, 2'b00, 9'd0, 9'd6, 2'b00);
        check("bp_c0_ready", 64'(ready), 64'b10);
        tick();
        req(2'b10, 2'b00, 9'd0, 9'd6, 2'b00);
        check("bp_c1_ready",  64'(ready),   64'b00);
        check("bp_c1_data_v", 64'(data_v),  64'b10);
        check("bp_c1_data1",  data[127:64], 64'hCAFE_F00D_1234_5678);
        tick();
        req(2'b11, 2'b00, 9'd5, 9'd6, 2'b00);
        check("bp_c2_ready",  64'(ready),   64'b01);
        check("bp_c2_data1",  data[127:64], 64'hCAFE_F00D_1234_5678);
        tick();
        d1 = 64'h0123_4567_89AB_CDEF; m1 = 8'hFF;
        req(2'b10, 2'b10, 9'd0, 9'd7, 2'b01);
        check("bp_c3_wr_ready", 64'(ready),   64'b10);
        check("bp_c3_mem_w",    64'(mem_w),   64'd1);
        check("bp_c3_data_v",   64'(data_v),  64'b11);
        check("bp_c3_data0",    data[63:0],   64'h0000_0000_5566_7788);
        check("bp_c3_data1",    data[127:64], 64'hCAFE_F00D_1234_5678);
        tick();
        req(2'b10, 2'b00, 9'd0, 9'd7, 2'b00);
        check("bp_c4_ready", 64'(ready),   64'b00);
        check("bp_c4_data1", data[127:64], 64'hCAFE_F00D_1234_5678);
        tick();
        check("bp_c5_ready", 64'(ready),   64'b00);
        check("bp_c5_data1", data[127:64], 64'hCAFE_F00D_1234_5678);
        tick();
        req(2'b10, 2'b00, 9'd0, 9'd7, 2'b10);
        check("bp_c6_ready",  64'(ready),   64'b10);
        check("bp_c6_data_v", 64'(data_v),  64'b10);
        check("bp_c6_data1",  data[127:64], 64'hCAFE_F00D_1234_5678);
        tick();
        req(2'b00, 2'b00, 9'd0, 9'd7, 2'b10);
        check("bp_c7_data_v", 64'(data_v),  64'b10);
        check("bp_c7_data1",  data[127:64], 64'h0123_4567_89AB_CDEF);
        tick();
        req(2'b00, 2'b00, 9'd0, 9'd0, 2'b00);
        check("bp_c8_data_v", 64'(data_v), 64'b00);

        // Port 0 streams reads over addr 0..7 with yumi high: no bubbles.
        exp_rd[0] = 64'd0; exp_rd[1] = 64'd0; exp_rd[2] = 64'd0; exp_rd[3] = 64'd0;
        exp_rd[4] = 64'd0;
        exp_rd[5] = 64'h0000_0000_5566_7788;
        exp_rd[6] = 64'hCAFE_F00D_1234_5678;
        exp_rd[7] = 64'h0123_4567_89AB_CDEF;
        for (int i = 0; i < 8; i++) begin
            req(2'b01, 2'b00, 9'(i), 9'd0, 2'b01);
            check("st_ready", 64'(ready), 64'b01);
            if (i > 0) begin
                check("st_data_v", 64'(data_v[0]), 64'd1);
                check("st_data",   data[63:0],     exp_rd[i-1]);
            end
            tick();
        end
        req(2'b00, 2'b00, 9'd0, 9'd0, 2'b01);
        check("st_last_v",    64'(data_v[0]), 64'd1);
        check("st_last_data", data[63:0],     exp_rd[7]);
        tick();
        req(2'b00, 2'b00, 9'd0, 9'd0, 2'b00);
        check("st_end_v", 64'(data_v), 64'b00);

        // Reset in the middle of activity: port 1 full, port 0 inflight.
        req(2'b10, 2'b00, 9'd0, 9'd6, 2'b00);
        check("mr_rd1_ready", 64'(ready), 64'b10);
        tick();
        req(2'b00, 2'b00, 9'd0, 9'd6, 2'b00);
        check("mr_inflight1", 64'(data_v), 64'b10);
        tick();
        req(2'b01, 2'b00, 9'd5, 9'd0, 2'b00);
        check("mr_rd0_ready", 64'(ready), 64'b01);
        tick();
        req(2'b00, 2'b00, 9'd0, 9'd0, 2'b00);
        check("mr_pre_data_v", 64'(data_v),  64'b11);
        check("mr_pre_data1",  data[127:64], 64'hCAFE_F00D_1234_5678);
        check("mr_pre_data0",  data[63:0],   64'h0000_0000_5566_7788);
        reset_n = 1'b0;
        #1;
        check("mr_rst_data_v",    64'(data_v),    64'b00);
        check("mr_rst_ready",     64'(ready),     64'b00);
        check("mr_rst_mem_v",     64'(mem_v),     64'd0);
        check("mr_rst_init_done", 64'(init_done), 64'd0);
        tick();
        tick();
        reset_n = 1'b1;
        req(2'b11, 2'b00, 9'd5, 9'd6, 2'b00);
        init_check();
        check("mr_post_data_v", 64'(data_v), 64'b00);
        tick();
        check("mr_post_data_v2", 64'(data_v), 64'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
